series_sequencer: RTL and testbench

- FSM controller that sequences the truncated power-series datapath (x/y registers, temp/result registers, coefficient LUT with address counter, shared main multiplier fed by coeffmult/xmult bus select, y-vs-temp comparator).
- On start: loads operands, initialises registers, then iterates term_k = term_(k-1) * (-x^2) * ratio_k while accumulating into result.
- Terminates when the comparator reports the term below threshold (gt) or after MAX_TERMS accumulations.
- Sits directly beside the datapath and drives every control input; the top level sees only start/busy/done.

---
 rtl/series_sequencer_if.sv | 29 ++
 rtl/series_sequencer.sv | 129 ++++++++++++
 tb/tb_series_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/series_sequencer_if.sv
// Control bundle between the series sequencer and its power-series datapath.
// The master side is the sequencer: it samples start/gt and drives every
// load/init/select strobe plus the busy/done status.
interface series_sequencer_if;
  logic start;
  logic gt;
  logic ldx;
  logic ldy;
  logic ldr;
  logic ldt;
  logic ldadr;
  logic initr;
  logic initt;
  logic zadr;
  logic xmult;
  logic coeffmult;
  logic busy;
  logic done;

  modport master (
    input  start, gt,
    output ldx, ldy, ldr, ldt, ldadr, initr, initt, zadr, xmult, coeffmult, busy, done
  );

  modport slave (
    output start, gt,
    input  ldx, ldy, ldr, ldt, ldadr, initr, initt, zadr, xmult, coeffmult, busy, done
  );
endinterface

// File: rtl/series_sequencer.sv
// Sequencer for the truncated power-series evaluator. Each term is produced as
// term_k = term_(k-1) * (-x^2) * ratio_k on the shared multiplier (MULX then
// MULC), checked against y, and accumulated into result in ACC. The run ends
// when the comparator says the term is negligible or MAX_TERMS are summed.
module series_sequencer #(
  parameter int unsigned MAX_TERMS = 8
) (
  input  logic                clk,
  input  logic                rst,
  series_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAcc,
    StMulx,
    StMulc,
    StChk,
    StDone
  } state_e;

  typedef struct packed {
    logic ldx;
    logic ldy;
    logic ldr;
    logic ldt;
    logic ldadr;
    logic initr;
    logic initt;
    logic zadr;
    logic xmult;
    logic coeffmult;
    logic busy;
    logic done;
  } ctrl_t;

  localparam logic [4:0] MaxTerms = 5'(MAX_TERMS);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] cnt_inc;
  ctrl_t      ctrl_q, ctrl_d;

  assign cnt_inc = cnt_q + 5'd1;

  // Next state and term counter; start is only honoured while not busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: if (bus.start) state_d = StLoad;
      StLoad: begin
        cnt_d   = '0;
        state_d = StAcc;
      end
      StAcc: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == MaxTerms) ? StDone : StMulx;
      end
      StMulx: state_d = StMulc;
      StMulc: state_d = StChk;
      // A term below threshold is dropped, not accumulated.
      StChk:  state_d = bus.gt ? StDone : StAcc;
      StDone: if (bus.start) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // Control word for the upcoming state, so outputs leave the flops glitch-free.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      StLoad: begin
        ctrl_d.ldx   = 1'b1;
        ctrl_d.ldy   = 1'b1;
        ctrl_d.initr = 1'b1;
        ctrl_d.initt = 1'b1;
        ctrl_d.zadr  = 1'b1;
        ctrl_d.busy  = 1'b1;
      end
      StAcc: begin
        ctrl_d.ldr  = 1'b1;
        ctrl_d.busy = 1'b1;
      end
      StMulx: begin
        ctrl_d.xmult = 1'b1;
        ctrl_d.ldt   = 1'b1;
        ctrl_d.busy  = 1'b1;
      end
      StMulc: begin
        ctrl_d.coeffmult = 1'b1;
        ctrl_d.ldt       = 1'b1;
        ctrl_d.ldadr     = 1'b1;
        ctrl_d.busy      = 1'b1;
      end
      StChk:   ctrl_d.busy = 1'b1;
      StDone:  ctrl_d.done = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  // State, counter and registered Moore outputs; reset aborts a run at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.ldx       = ctrl_q.ldx;
  assign bus.ldy       = ctrl_q.ldy;
  assign bus.ldr       = ctrl_q.ldr;
  assign bus.ldt       = ctrl_q.ldt;
  assign bus.ldadr     = ctrl_q.ldadr;
  assign bus.initr     = ctrl_q.initr;
  assign bus.initt     = ctrl_q.initt;
  assign bus.zadr      = ctrl_q.zadr;
  assign bus.xmult     = ctrl_q.xmult;
  assign bus.coeffmult = ctrl_q.coeffmult;
  assign bus.busy      = ctrl_q.busy;
  assign bus.done      = ctrl_q.done;

endmodule

// File: tb/tb_series_sequencer.sv
// Bench for series_sequencer. A queue model expands each accepted start into
// the full per-cycle control trace of one run; every negedge the DUT outputs
// are compared with the model's current word, and literal latency/count checks
// pin the model itself.
module tb_series_sequencer;
  localparam int unsigned M = 8;

  // Word order: ldx ldy ldr ldt ldadr initr initt zadr xmult coeffmult busy done
  localparam logic [11:0] W_IDLE = 12'b000000000000;
  localparam logic [11:0] W_LOAD = 12'b110001110010;
  localparam logic [11:0] W_ACC  = 12'b001000000010;
  localparam logic [11:0] W_MULX = 12'b000100001010;
  localparam logic [11:0] W_MULC = 12'b000110000110;
  localparam logic [11:0] W_CHK  = 12'b000000000010;
  localparam logic [11:0] W_DONE = 12'b000000000001;

  logic clk = 1'b0;
  logic rst;

  series_sequencer_if bus_if ();

  series_sequencer #(.MAX_TERMS(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  logic [11:0] act;
  assign act = {bus_if.ldx, bus_if.ldy, bus_if.ldr, bus_if.ldt, bus_if.ldadr, bus_if.initr,
                bus_if.initt, bus_if.zadr, bus_if.xmult, bus_if.coeffmult, bus_if.busy,
                bus_if.done};

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int run_edge = 0;
  int done_ofs = -1;
  int n_ldr, n_ldt, n_ldadr, n_load;
  int plan_exit = 0;          // term whose CHK sees gt=1; 0 or >=M means never
  logic noise_en = 1'b0;

  // Bit 12 marks the CHK cycle where the bench raises gt.
  logic [12:0] q[$];
  logic [12:0] cur = 13'b0;
  logic [11:0] rest = W_IDLE;

  task automatic chk(input string nm, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic clear_counts();
    n_ldr = 0; n_ldt = 0; n_ldadr = 0; n_load = 0; done_ofs = -1;
  endtask

  // One run: LOAD, then M accumulations separated by MULX/MULC/CHK, cut short
  // at the CHK where gt is raised.
  function automatic void build(input int e);
    q.push_back({1'b0, W_LOAD});
    for (int k = 1; k <= int'(M); k++) begin
      q.push_back({1'b0, W_ACC});
      if (k == int'(M)) break;
      q.push_back({1'b0, W_MULX});
      q.push_back({1'b0, W_MULC});
      q.push_back({(k == e), W_CHK});
      if (k == e) break;
    end
  endfunction

  // Model: advances one cycle per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        q.delete();
        rest = W_IDLE;
        cur  = {1'b0, W_IDLE};
      end else if (!cur[1] && bus_if.start) begin
        build(plan_exit);
        rest     = W_DONE;
        run_edge = edge_n;
        cur      = q.pop_front();
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur = {1'b0, rest};
      end
    end
  end

  // gt: forced by the plan in CHK cycles, random noise elsewhere.
  initial begin
    bus_if.gt = 1'b0;
    forever begin
      @(negedge clk);
      if (cur[12]) bus_if.gt = 1'b1;
      else if (cur[11:0] == W_CHK) bus_if.gt = 1'b0;
      else bus_if.gt = noise_en ? 1'($urandom_range(1, 0)) : 1'b0;
    end
  end

  // Compare process: every cycle against the model, plus invariants and counts.
  initial begin
    logic dprev;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      tests++;
      if (act !== cur[11:0]) begin
        fails++;
        $display("FAIL trace: got %b expected %b (edge %0d)", act, cur[11:0], edge_n);
      end
      chk("xmult_and_coeffmult", int'(bus_if.xmult & bus_if.coeffmult), 0);
      chk("ldt_and_ldr", int'(bus_if.ldt & bus_if.ldr), 0);
      chk("busy_and_done", int'(bus_if.busy & bus_if.done), 0);
      if (bus_if.ldr === 1'b1) n_ldr++;
      if (bus_if.ldt === 1'b1) n_ldt++;
      if (bus_if.ldadr === 1'b1) n_ldadr++;
      if ((bus_if.ldx & bus_if.ldy & bus_if.initr & bus_if.initt & bus_if.zadr) === 1'b1)
        n_load++;
      if (bus_if.done === 1'b1 && !dprev) done_ofs = edge_n - run_edge;
      dprev = (bus_if.done === 1'b1);
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus_if.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_done: timed out after %0d cycles, done=%b required 1", n, bus_if.done);
    end
  endtask

  // Call at a negedge; returns at the negedge of the LOAD cycle.
  task automatic run_pulse();
    clear_counts();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic chk_counts(input string nm, input int ofs, input int ldr, input int ldt,
                            input int ldadr);
    chk({nm, "_done_edge"}, done_ofs, ofs);
    chk({nm, "_ldr"}, n_ldr, ldr);
    chk({nm, "_ldt"}, n_ldt, ldt);
    chk({nm, "_ldadr"}, n_ldadr, ldadr);
    chk({nm, "_load"}, n_load, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.start = 1'b1;
    clear_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_idle", int'(act), 0);

    // Full run, gt never asserted.
    run_pulse();
    wait_done(100);
    chk_counts("full", 30, 8, 14, 7);

    // Early exit at the first CHK.
    plan_exit = 1;
    run_pulse();
    wait_done(100);
    chk_counts("early", 5, 1, 2, 1);

    // Start pulsed during MULX must be ignored.
    plan_exit = 0;
    run_pulse();
    repeat (2) @(negedge clk);
    chk("mulx_phase", int'(bus_if.xmult), 1);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done(100);
    chk_counts("ignored", 30, 8, 14, 7);

    // Restart straight from DONE, exiting at the third CHK.
    plan_exit = 3;
    clear_counts();
    bus_if.start = 1'b1;
    @(negedge clk);
    chk("restart_busy", int'(bus_if.busy), 1);
    chk("restart_done", int'(bus_if.done), 0);
    chk("restart_ldx", int'(bus_if.ldx), 1);
    bus_if.start = 1'b0;
    wait_done(100);
    chk_counts("restart", 13, 3, 6, 3);

    // Reset during MULC of term 3, then a fresh full run.
    plan_exit = 0;
    run_pulse();
    repeat (11) @(negedge clk);
    chk("mulc_t3", int'(bus_if.coeffmult), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle", int'(act), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_stays_idle", int'(act), 0);
    run_pulse();
    wait_done(100);
    chk_counts("fresh", 30, 8, 14, 7);

    // Randomised gt plans, some with start held high through the run.
    noise_en = 1'b1;
    for (int r = 0; r < 200; r++) begin
      logic hold;
      plan_exit = int'($urandom_range(M, 0));
      hold = 1'($urandom_range(1, 0));
      clear_counts();
      bus_if.start = 1'b1;
      @(negedge clk);
      if (!hold) bus_if.start = 1'b0;
      wait_done(200);
      if (hold) begin
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(200);
      end
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    noise_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
